// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scan interface:
// segment patterns (bit0=a .. bit6=g), decoded code values and decoder FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_PAT_0 = 7'h3F;
    localparam logic [6:0] SEG_PAT_1 = 7'h06;
    localparam logic [6:0] SEG_PAT_2 = 7'h5B;
    localparam logic [6:0] SEG_PAT_3 = 7'h4F;
    localparam logic [6:0] SEG_PAT_4 = 7'h66;
    localparam logic [6:0] SEG_PAT_5 = 7'h6D;
    localparam logic [6:0] SEG_PAT_6 = 7'h7D;
    localparam logic [6:0] SEG_PAT_7 = 7'h27;
    localparam logic [6:0] SEG_PAT_8 = 7'h7F;
    localparam logic [6:0] SEG_PAT_9 = 7'h6F;
    localparam logic [6:0] SEG_PAT_BLANK = 7'h00;

    // Codes reported for non-digit slots: all segments dark vs. an unknown pattern.
    localparam logic [3:0] SEG_BLANK   = 4'hF;
    localparam logic [3:0] SEG_INVALID = 4'hE;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Maps a 7-bit segment pattern to its BCD digit, the blank code or the invalid code.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] code_o
);

    // Pure lookup; anything that is not one of the ten digit shapes or blank is invalid.
    always_comb begin
        code_o = SEG_INVALID;
        case (pattern_i)
            SEG_PAT_0:     code_o = 4'd0;
            SEG_PAT_1:     code_o = 4'd1;
            SEG_PAT_2:     code_o = 4'd2;
            SEG_PAT_3:     code_o = 4'd3;
            SEG_PAT_4:     code_o = 4'd4;
            SEG_PAT_5:     code_o = 4'd5;
            SEG_PAT_6:     code_o = 4'd6;
            SEG_PAT_7:     code_o = 4'd7;
            SEG_PAT_8:     code_o = 4'd8;
            SEG_PAT_9:     code_o = 4'd9;
            SEG_PAT_BLANK: code_o = SEG_BLANK;
            default:       code_o = SEG_INVALID;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receiver for the multiplexed 7-segment scan bus: waits for each slot to settle,
// collects slots 0..3 in order into shadow registers and commits whole frames.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk0,
    input  logic        rst_n,
    input  logic [7:0]  seg7,
    input  logic [3:0]  line,
    input  logic        err_clr,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        frame_valid,
    output logic        locked,
    output logic        err_seq,
    output logic        err_line
);

    localparam logic [7:0] SETTLE_MAX  = 8'(SETTLE_CYCLES);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    logic [10:0]      scanIn_d;
    logic [10:0]      scanIn_q;
    logic [7:0]       settle_q;
    logic             sampleEvent;
    logic             unusedDp;
    logic [3:0]       lineQ;
    logic             lineOneHot;
    logic             lineMultiHot;
    logic [1:0]       slotIdx;
    logic [3:0]       slotCode;

    scan_state_e      state_q;
    logic [1:0]       exp_q;
    logic [1:0]       expPrev;
    logic [3:0][3:0]  shadow_q;
    logic             commit_q;
    logic [15:0]      digits_q;
    logic [3:0]       digitValid_q;
    logic             frameValid_q;
    logic             locked_q;
    logic             errSeq_q;
    logic             errLine_q;

    // The decimal point carries no digit information and is dropped at the input.
    assign unusedDp = seg7[7];
    assign scanIn_d = {line, seg7[6:0]};

    // Input register plus stability counter; any change in the registered bus restarts settling.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            scanIn_q <= '0;
            settle_q <= '0;
        end else begin
            scanIn_q <= scanIn_d;
            if (scanIn_d != scanIn_q) begin
                settle_q <= '0;
            end else if (settle_q != SETTLE_MAX) begin
                settle_q <= settle_q + 8'd1;
            end
        end
    end

    // Fires once per stable slot, on the cycle the counter reaches saturation.
    assign sampleEvent = (scanIn_d == scanIn_q) && (settle_q == SETTLE_LAST);

    assign lineQ = scanIn_q[10:7];

    // Classify the digit select and find the active slot.
    always_comb begin
        lineOneHot = 1'b1;
        slotIdx    = 2'd0;
        case (lineQ)
            4'b0001: slotIdx = 2'd0;
            4'b0010: slotIdx = 2'd1;
            4'b0100: slotIdx = 2'd2;
            4'b1000: slotIdx = 2'd3;
            default: lineOneHot = 1'b0;
        endcase
    end

    assign lineMultiHot = (lineQ != 4'b0000) && !lineOneHot;
    assign expPrev      = exp_q - 2'd1;

    seg7_pattern_decode uDecode (
        .pattern_i (scanIn_q[6:0]),
        .code_o    (slotCode)
    );

    // Slot sequencing FSM with shadow collection, atomic frame commit and sticky error flags.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            exp_q        <= 2'd0;
            shadow_q     <= {4{SEG_BLANK}};
            commit_q     <= 1'b0;
            digits_q     <= 16'hFFFF;
            digitValid_q <= 4'b0000;
            frameValid_q <= 1'b0;
            locked_q     <= 1'b0;
            errSeq_q     <= 1'b0;
            errLine_q    <= 1'b0;
        end else begin
            frameValid_q <= 1'b0;
            commit_q     <= 1'b0;

            if (err_clr) begin
                errSeq_q  <= 1'b0;
                errLine_q <= 1'b0;
            end

            if (commit_q) begin
                digits_q     <= shadow_q;
                for (int k = 0; k < 4; k++) begin
                    digitValid_q[k] <= (shadow_q[k] <= 4'd9);
                end
                frameValid_q <= 1'b1;
            end

            if (sampleEvent && lineMultiHot) begin
                errLine_q <= 1'b1;
            end

            if (sampleEvent && lineOneHot) begin
                case (state_q)
                    HUNT: begin
                        if (slotIdx == 2'd0) begin
                            shadow_q[0] <= slotCode;
                            exp_q       <= 2'd1;
                            state_q     <= COLLECT;
                            locked_q    <= 1'b1;
                        end
                    end
                    COLLECT: begin
                        if (slotIdx == exp_q) begin
                            shadow_q[slotIdx] <= slotCode;
                            exp_q             <= exp_q + 2'd1;
                            commit_q          <= (slotIdx == 2'd3);
                        end else if (slotIdx == expPrev) begin
                            shadow_q[slotIdx] <= slotCode;
                            commit_q          <= (slotIdx == 2'd3);
                        end else begin
                            errSeq_q <= 1'b1;
                            state_q  <= HUNT;
                            locked_q <= 1'b0;
                            exp_q    <= 2'd0;
                            shadow_q <= {4{SEG_BLANK}};
                        end
                    end
                endcase
            end
        end
    end

    assign digits      = digits_q;
    assign digit_valid = digitValid_q;
    assign frame_valid = frameValid_q;
    assign locked      = locked_q;
    assign err_seq     = errSeq_q;
    assign err_line    = errLine_q;

endmodule
